// File: rtl/bpa_frame_checker.sv
// Receive-side frame checker: gathers N_WORDS data words plus a trailing checksum word,
// rebuilds the packed frame and verifies that checksum == -(sum of data words) mod 2^WORD_W.
module bpa_frame_checker #(
    parameter int WORD_W  = 10,
    parameter int N_WORDS = 48,
    parameter int ERR_W   = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W-1:0]           in_data,
    input  logic                        in_abort,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_WORDS*WORD_W-1:0]   frame_data,
    output logic                        frame_ok,
    output logic [ERR_W-1:0]            err_cnt
);

    localparam int IDX_W = $clog2(N_WORDS + 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_CHECK   = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WORD_W-1:0]   acc;
    logic [IDX_W-1:0]    idx;
    logic                take;
    logic                last_word;
    logic                out_hs;
    logic [WORD_W-1:0]   chk_sum;

    function automatic logic [WORD_W-1:0] mod_add(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        return a + b;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    // An abort coinciding with a handshake drops the word.
    assign take      = in_valid && in_ready && !in_abort;
    assign last_word = (idx == IDX_W'(N_WORDS - 1));
    assign out_hs    = out_valid && out_ready;
    assign chk_sum   = mod_add(acc, in_data);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: begin
                if (take && last_word) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (in_abort) begin
                    state_nxt = S_COLLECT;
                end else if (take) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_hs) begin
                    state_nxt = S_COLLECT;
                end
            end
            default: state_nxt = S_COLLECT;
        endcase
    end

    // Handshake outputs depend on the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_COLLECT: in_ready  = 1'b1;
            S_CHECK:   in_ready  = 1'b1;
            S_HOLD:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc      <= '0;
            idx      <= '0;
            frame_ok <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (state != S_HOLD && in_abort) begin
                acc <= '0;
                idx <= '0;
            end else if (state == S_COLLECT && take) begin
                acc <= chk_sum;
                idx <= idx + IDX_W'(1);
            end else if (state == S_CHECK && take) begin
                frame_ok <= (chk_sum == '0);
                if (chk_sum != '0) begin
                    err_cnt <= sat_inc(err_cnt);
                end
            end else if (state == S_HOLD && out_hs) begin
                acc <= '0;
                idx <= '0;
            end
        end
    end

    // Slices are overwritten in place; stale contents outside HOLD are harmless.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_data <= '0;
        end else begin
            for (int k = 0; k < N_WORDS; k++) begin
                if (state == S_COLLECT && take && idx == IDX_W'(k)) begin
                    frame_data[k*WORD_W +: WORD_W] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_bpa_frame_checker.sv
// Directed bench for bpa_frame_checker with hand-computed checksums and expected frames.
module tb_bpa_frame_checker;

    localparam int W  = 10;
    localparam int N  = 48;
    localparam int E  = 8;
    localparam int FW = N * W;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_abort;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] frame_data;
    logic          frame_ok;
    logic [E-1:0]  err_cnt;

    int            n_chk  = 0;
    int            n_pass = 0;
    logic [W-1:0]  wbuf [N];
    logic [FW-1:0] exp_frame;

    always #5 clk = ~clk;

    bpa_frame_checker #(.WORD_W(W), .N_WORDS(N), .ERR_W(E)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_abort   (in_abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_data (frame_data),
        .frame_ok   (frame_ok),
        .err_cnt    (err_cnt)
    );

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic fill_const(input logic [W-1:0] v);
        for (int k = 0; k < N; k++) wbuf[k] = v;
        for (int k = 0; k < N; k++) exp_frame[k*W +: W] = v;
    endtask

    task automatic fill_inc();
        for (int k = 0; k < N; k++) wbuf[k] = W'(k);
        for (int k = 0; k < N; k++) exp_frame[k*W +: W] = W'(k);
    endtask

    task automatic send_word(input logic [W-1:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
    endtask

    // Leaves the caller at the negedge right after the checksum edge.
    task automatic send_frame(input logic [W-1:0] ck);
        for (int k = 0; k < N; k++) send_word(wbuf[k]);
        @(negedge clk);
        chk("pre_ck_out_valid", FW'(out_valid), FW'(1'b0));
        in_valid = 1'b1;
        in_data  = ck;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("post_hs_out_valid", FW'(out_valid), FW'(1'b0));
        chk("post_hs_in_ready", FW'(in_ready), FW'(1'b1));
        out_ready = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_abort  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", FW'(in_ready), FW'(1'b1));
        chk("rst_out_valid", FW'(out_valid), FW'(1'b0));
        chk("rst_frame_ok", FW'(frame_ok), FW'(1'b0));
        chk("rst_err_cnt", FW'(err_cnt), FW'(0));
        chk("rst_frame_data", frame_data, '0);
        rstn = 1'b1;

        // All-ones frame: sum = -48, checksum 48.
        fill_const(10'h3FF);
        send_frame(10'd48);
        chk("ones_out_valid", FW'(out_valid), FW'(1'b1));
        chk("ones_in_ready", FW'(in_ready), FW'(1'b0));
        chk("ones_frame_ok", FW'(frame_ok), FW'(1'b1));
        chk("ones_frame_data", frame_data, {FW{1'b1}});
        chk("ones_err_cnt", FW'(err_cnt), FW'(0));
        release_out();

        // Incrementing frame: sum 104, checksum 920 good, 921 bad.
        fill_inc();
        send_frame(10'd920);
        chk("inc_frame_ok", FW'(frame_ok), FW'(1'b1));
        chk("inc_frame_data", frame_data, exp_frame);
        chk("inc_err_cnt", FW'(err_cnt), FW'(0));
        release_out();
        send_frame(10'd921);
        chk("bad_frame_ok", FW'(frame_ok), FW'(1'b0));
        chk("bad_err_cnt", FW'(err_cnt), FW'(1));

        // Backpressure in HOLD with in_valid driven.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
            chk("bp_in_ready", FW'(in_ready), FW'(1'b0));
            chk("bp_out_valid", FW'(out_valid), FW'(1'b1));
            chk("bp_frame_data", frame_data, exp_frame);
            chk("bp_frame_ok", FW'(frame_ok), FW'(1'b0));
            chk("bp_err_cnt", FW'(err_cnt), FW'(1));
        end
        release_out();
        fill_const(10'h3FF);
        send_frame(10'd48);
        chk("after_bp_frame_ok", FW'(frame_ok), FW'(1'b1));
        chk("after_bp_frame_data", frame_data, {FW{1'b1}});
        chk("after_bp_err_cnt", FW'(err_cnt), FW'(1));
        release_out();

        // Abort at idx 20 together with a valid word.
        fill_inc();
        for (int k = 0; k < 20; k++) send_word(wbuf[k]);
        @(negedge clk);
        in_valid = 1'b1;
        in_abort = 1'b1;
        in_data  = 10'h155;
        @(posedge clk);
        @(negedge clk);
        in_abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_in_ready", FW'(in_ready), FW'(1'b1));
        chk("abort_out_valid", FW'(out_valid), FW'(1'b0));
        send_frame(10'd920);
        chk("abort_out_valid_end", FW'(out_valid), FW'(1'b1));
        chk("abort_frame_ok", FW'(frame_ok), FW'(1'b1));
        chk("abort_frame_data", frame_data, exp_frame);
        chk("abort_err_cnt", FW'(err_cnt), FW'(1));
        release_out();

        // Reset after 30 words.
        fill_const(10'h2AA);
        for (int k = 0; k < 30; k++) send_word(wbuf[k]);
        @(negedge clk);
        in_valid = 1'b0;
        rstn     = 1'b0;
        #1;
        chk("mid_rst_in_ready", FW'(in_ready), FW'(1'b1));
        chk("mid_rst_out_valid", FW'(out_valid), FW'(1'b0));
        chk("mid_rst_frame_ok", FW'(frame_ok), FW'(1'b0));
        chk("mid_rst_err_cnt", FW'(err_cnt), FW'(0));
        chk("mid_rst_frame_data", frame_data, '0);
        @(negedge clk);
        rstn = 1'b1;
        fill_inc();
        send_frame(10'd920);
        chk("post_rst_frame_ok", FW'(frame_ok), FW'(1'b1));
        chk("post_rst_frame_data", frame_data, exp_frame);
        chk("post_rst_err_cnt", FW'(err_cnt), FW'(0));
        release_out();

        // Saturation: zero data with checksum 1 is always wrong.
        fill_const(10'h000);
        for (int f = 0; f < 255; f++) begin
            send_frame(10'd1);
            release_out();
        end
        chk("sat_err_cnt_255", FW'(err_cnt), FW'(255));
        for (int f = 0; f < 5; f++) begin
            send_frame(10'd1);
            chk("sat_frame_ok", FW'(frame_ok), FW'(1'b0));
            chk("sat_err_cnt_hold", FW'(err_cnt), FW'(255));
            release_out();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
